// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS instruction-memory boot loader.
package mips_loader_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam int         LEN_W          = 16;
  localparam logic [7:0] CSUM_SEED      = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/rx_word_packer.sv
// Packs a byte stream into big-endian 32-bit words and keeps a running XOR.
// Only the first three bytes of a word are stored; the fourth byte is
// combined on the fly, so word_o is the complete word while word_full_o is set.
module rx_word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [7:0]  csum_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;

  // Next-state: clear wins over shift; a shift stores the byte and folds it into the checksum.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    if (clear_i) begin
      sh_d   = '0;
      cnt_d  = '0;
      csum_d = CSUM_SEED;
    end else if (shift_en_i) begin
      sh_d   = {sh_q[15:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
      csum_d = csum_q ^ byte_i;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      csum_q <= CSUM_SEED;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
    end
  end

  assign word_o      = {sh_q, byte_i};
  assign word_full_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign csum_o      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte image, writes it into instruction
// memory and keeps the core in reset until the image checksum matches.
//
// state  | meaning
// IDLE   | waiting for i_start after reset
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte, range check
// DATA   | collecting payload bytes of the current word
// WRITE  | one-cycle memory write, stream stalled
// CSUM   | expecting checksum byte
// DONE   | image verified, core released
// ERR    | bad length or checksum, core held in reset
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = mips_loader_pkg::LEN_W
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  import mips_loader_pkg::*;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(1 << ADDR_W);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_full;
  logic [ADDR_W:0]    idx_q, idx_d, idx_inc;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               cpu_reset_q;

  logic               accept;
  logic               start_load;
  logic               pk_shift;
  logic [31:0]        pk_word;
  logic               pk_full;
  logic [7:0]         pk_csum;

  assign o_rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CSUM);
  assign o_busy     = o_rx_ready || (state_q == WRITE);
  assign o_done     = (state_q == DONE);
  assign o_err      = (state_q == ERR);

  assign accept     = i_rx_valid && o_rx_ready;
  assign start_load = i_start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign pk_shift   = accept && (state_q == DATA);
  assign len_full   = {len_q[15:8], i_rx_data};
  assign idx_inc    = idx_q + (ADDR_W + 1)'(1);

  rx_word_packer u_packer (
    .clk_i       (i_clk),
    .rst_ni      (reset),
    .clear_i     (start_load),
    .shift_en_i  (pk_shift),
    .byte_i      (i_rx_data),
    .word_o      (pk_word),
    .word_full_o (pk_full),
    .csum_o      (pk_csum)
  );

  // Frame sequencing, word addressing and write-port staging.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_load) begin
          state_d = LEN_HI;
          len_d   = '0;
          idx_d   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {i_rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full > DEPTH_L)      state_d = ERR;
          else if (len_full == '0)     state_d = CSUM;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        // The fourth byte completes the word; stage the write so o_we is registered.
        if (accept && pk_full) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = 32'({idx_q[ADDR_W-1:0], 2'b00});
          wdata_d = pk_word;
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (LEN_W'(idx_inc) == len_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) state_d = (i_rx_data == pk_csum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; the core runs only while the next state is DONE.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= (state_d != DONE);
    end
  end

  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors, length limits,
// back-to-back streaming and mid-load reset.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_cpu_reset;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stim[$];
  int          stalls;
  int          n_wr;
  logic [31:0] wr_addr[0:79];
  logic [31:0] wr_data[0:79];

  imem_loader #(.ADDR_W(6), .LEN_W(16)) dut (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_addr      (o_addr),
    .o_wdata     (o_wdata),
    .o_cpu_reset (o_cpu_reset),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Capture every write pulse, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_we) begin
      if (n_wr < 80) begin
        wr_addr[n_wr] = o_addr;
        wr_data[n_wr] = o_wdata;
      end
      n_wr = n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Offer one byte with valid held; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = o_rx_ready;
      if (!ok) stalls++;
      @(negedge i_clk);
    end
    if (!ok) chk("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_stim();
    stalls = 0;
    foreach (stim[i]) send_byte(stim[i]);
    i_rx_valid = 1'b0;
  endtask

  task automatic load_good_frame();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
  endtask

  initial begin
    logic [7:0]  pb;
    logic [7:0]  xs;
    logic [31:0] ew;

    reset      = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    n_wr       = 0;
    stalls     = 0;
    repeat (3) @(negedge i_clk);

    chk("rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
    chk("rst_we",        32'(o_we),        32'd0);
    chk("rst_ready",     32'(o_rx_ready),  32'd0);
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_done",      32'(o_done),      32'd0);
    chk("rst_err",       32'(o_err),       32'd0);
    chk("rst_addr",      o_addr,           32'd0);
    chk("rst_wdata",     o_wdata,          32'd0);

    reset = 1'b1;
    @(negedge i_clk);

    // Good two-word frame, valid held high throughout.
    n_wr = 0;
    pulse_start();
    chk("s1_busy", 32'(o_busy), 32'd1);
    load_good_frame();
    send_stim();
    chk("s1_nwr",   32'(n_wr),  32'd2);
    chk("s1_addr0", wr_addr[0], 32'h0000_0000);
    chk("s1_data0", wr_data[0], 32'h2008_0005);
    chk("s1_addr1", wr_addr[1], 32'h0000_0004);
    chk("s1_data1", wr_data[1], 32'h0109_5020);
    chk("s1_stalls", 32'(stalls), 32'd2);
    chk("s1_done",  32'(o_done),      32'd1);
    chk("s1_err",   32'(o_err),       32'd0);
    chk("s1_cpurst", 32'(o_cpu_reset), 32'd0);
    chk("s1_busy_end", 32'(o_busy),   32'd0);
    chk("s1_hold_addr",  o_addr,  32'h0000_0004);
    chk("s1_hold_wdata", o_wdata, 32'h0109_5020);

    // Bad checksum, restart from DONE, stray i_start during DATA.
    n_wr = 0;
    pulse_start();
    chk("s2_cpurst_reassert", 32'(o_cpu_reset), 32'd1);
    chk("s2_ready", 32'(o_rx_ready), 32'd1);
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    send_stim();
    i_start = 1'b1;
    send_byte(8'h05);
    send_byte(8'h01);
    i_start = 1'b0;
    stim = '{8'h09, 8'h50, 8'h20, 8'h54};
    send_stim();
    chk("s2_nwr",   32'(n_wr),  32'd2);
    chk("s2_data0", wr_data[0], 32'h2008_0005);
    chk("s2_data1", wr_data[1], 32'h0109_5020);
    chk("s2_err",   32'(o_err),       32'd1);
    chk("s2_done",  32'(o_done),      32'd0);
    chk("s2_cpurst", 32'(o_cpu_reset), 32'd1);

    // Empty image with zero checksum.
    n_wr = 0;
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim();
    chk("s3_nwr",   32'(n_wr),        32'd0);
    chk("s3_done",  32'(o_done),      32'd1);
    chk("s3_cpurst", 32'(o_cpu_reset), 32'd0);

    // Empty image with nonzero checksum.
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h01};
    send_stim();
    chk("s4_err",   32'(o_err),       32'd1);
    chk("s4_cpurst", 32'(o_cpu_reset), 32'd1);

    // Word count one beyond DEPTH: rejected after the length, no further bytes taken.
    n_wr = 0;
    pulse_start();
    stim = '{8'h00, 8'h41};
    send_stim();
    chk("s5_err",   32'(o_err),      32'd1);
    chk("s5_ready", 32'(o_rx_ready), 32'd0);
    i_rx_data  = 8'hAB;
    i_rx_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("s5_ready_held", 32'(o_rx_ready), 32'd0);
    chk("s5_still_err",  32'(o_err),      32'd1);
    chk("s5_nwr",        32'(n_wr),       32'd0);
    i_rx_valid = 1'b0;

    // Word count exactly DEPTH fills the whole memory.
    n_wr = 0;
    pulse_start();
    stim = '{8'h00, 8'h40};
    xs = 8'h00;
    for (int j = 0; j < 256; j++) begin
      pb = 8'(j * 7 + 3);
      stim.push_back(pb);
      xs = xs ^ pb;
    end
    stim.push_back(xs);
    send_stim();
    chk("s6_nwr",  32'(n_wr),   32'd64);
    chk("s6_stalls", 32'(stalls), 32'd64);
    for (int w = 0; w < 64; w++) begin
      ew = {8'(4*w*7 + 3), 8'((4*w+1)*7 + 3), 8'((4*w+2)*7 + 3), 8'((4*w+3)*7 + 3)};
      chk($sformatf("s6_addr%0d", w), wr_addr[w], 32'(w * 4));
      chk($sformatf("s6_data%0d", w), wr_data[w], ew);
    end
    chk("s6_done",   32'(o_done),      32'd1);
    chk("s6_cpurst", 32'(o_cpu_reset), 32'd0);

    // Reset in the middle of the payload, then a clean reload.
    pulse_start();
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_stim();
    chk("s7_busy_before", 32'(o_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("s7_cpurst", 32'(o_cpu_reset), 32'd1);
    chk("s7_busy",   32'(o_busy),      32'd0);
    chk("s7_ready",  32'(o_rx_ready),  32'd0);
    chk("s7_we",     32'(o_we),        32'd0);
    chk("s7_addr",   o_addr,           32'd0);
    chk("s7_wdata",  o_wdata,          32'd0);
    chk("s7_done",   32'(o_done),      32'd0);
    @(negedge i_clk);
    reset = 1'b1;
    @(negedge i_clk);
    n_wr = 0;
    pulse_start();
    load_good_frame();
    send_stim();
    chk("s7_nwr",   32'(n_wr),  32'd2);
    chk("s7_data0", wr_data[0], 32'h2008_0005);
    chk("s7_data1", wr_data[1], 32'h0109_5020);
    chk("s7_redone", 32'(o_done),      32'd1);
    chk("s7_run",    32'(o_cpu_reset), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader upstream of the single-cycle MIPS core's instruction memory.
- Receives a framed byte stream over a valid/ready interface and packs it into 32-bit big-endian words.
- Writes the words into instruction memory and holds the core in reset until a checksum-verified image is in place.
- Releasing `o_cpu_reset` starts the core fetching from PC 0.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- LEN_W, 16, width of the frame word-count field (fixed frame format; do not change).

Ports:
- i_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- i_rx_data  in  8  stream byte.
- i_rx_valid  in  1  stream byte valid.
- o_rx_ready  out  1  loader can accept a byte.
- o_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- o_addr  out  32  byte address of the write (word_idx*4).
- o_wdata  out  32  assembled word.
- o_cpu_reset  out  1  active-high reset to the core's `reset` input.
- o_busy  out  1  high in LEN_HI, LEN_LO, DATA, WRITE, CSUM.
- o_done  out  1  level; high in DONE.
- o_err  out  1  level; high in ERR.

Behaviour:
- Frame format:
  - 2 bytes word count N, MSB first.
  - N*4 payload bytes, each word MSB first.
  - 1 checksum byte = XOR of all payload bytes; 0x00 when N=0.
- A byte is accepted when i_rx_valid && o_rx_ready on a rising edge.
- o_rx_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 elsewhere.
- Reset values (asynchronous):
  - state = IDLE; o_cpu_reset = 1; all other outputs 0.
  - Counters, shift register and checksum accumulator = 0.
- States and transitions:
  - IDLE: i_start -> LEN_HI.
  - LEN_HI: accept -> len[15:8]; go to LEN_LO.
  - LEN_LO: accept -> len[7:0]; then:
    - N > DEPTH -> ERR.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: each accepted byte shifts in (first byte lands in [31:24]) and XORs into the checksum. On the 4th byte -> WRITE.
  - WRITE (exactly 1 cycle):
    - o_we = 1, o_addr = {word_idx, 2'b00} zero-extended, o_wdata = assembled word.
    - word_idx increments.
    - If word_idx+1 == N -> CSUM, else -> DATA.
  - CSUM: accept; byte == accumulator -> DONE, else -> ERR.
  - DONE: o_cpu_reset = 0. i_start -> LEN_HI; o_cpu_reset re-asserts the next cycle and counters/accumulator clear.
  - ERR: o_cpu_reset = 1; i_start -> LEN_HI (same clearing).
- i_start is ignored while o_busy = 1.
- o_we/o_addr/o_wdata are registered. o_we rises the cycle after the 4th byte of a word is accepted.
- o_addr and o_wdata hold their last values outside WRITE.
- Max throughput: 4 bytes per 5 cycles (WRITE stalls the stream).
- Words already written before an error are not scrubbed.
- word_idx is ADDR_W+1 bits; N = DEPTH is legal, last o_addr = (DEPTH-1)*4.
- Reset asserted mid-load: immediate return to IDLE with reset values; partially written memory is left as is.
- o_cpu_reset is 0 only in DONE. The core never runs on a partial or unverified image.

Decomposition:
- Shared package `mips_loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR).
  - BYTES_PER_WORD = 4, LEN_W = 16, checksum seed 8'h00.
- One natural sub-module, `rx_word_packer`:
  - 8->32 shift register, 2-bit byte counter, XOR accumulator.
  - Inputs: shift enable and clear.
  - Outputs: word, word_full, csum.
  - FSM and address counter stay in imem_loader.

Test Plan:
- i_start, stream 00 02 20 08 00 05 01 09 50 20 55 -> o_we pulses addr 0 data 0x20080005, then addr 4 data 0x01095020; o_done=1, o_cpu_reset=0, o_err=0.
- Same stream with checksum 54 -> both writes still occur; o_err=1, o_done=0, o_cpu_reset stays 1.
- Stream 00 00 00 -> no o_we; DONE, o_cpu_reset=0. Stream 00 00 01 -> ERR.
- ADDR_W=6, stream 00 41 -> ERR right after 2nd byte, o_rx_ready=0, no writes, remaining bytes unconsumed.
- i_rx_valid held high continuously -> o_rx_ready low exactly 1 cycle per word (WRITE); no byte lost or duplicated; i_start pulsed mid-DATA has no effect.
- Assert reset after 2 payload bytes -> all outputs return to reset values asynchronously; a fresh i_start plus the full first-scenario stream completes with DONE.
